// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the ARM-subset core: instruction mode codes,
// data-processing opcodes, EX-stage ALU command codes, default widths and the
// decoded-control bundle carried from ID to EX.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

    // Default datapath widths
    localparam int unsigned CORE_WORD_W     = 32;
    localparam int unsigned CORE_REG_ADDR_W = 4;
    localparam int unsigned EX_CMD_W        = 4;

    // Instruction mode field (bits 27:26)
    typedef enum logic [1:0] {
        MODE_ARITH  = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10
    } mode_e;

    // Data-processing opcodes (bits 24:21)
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_EOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0100,
        OP_ADC = 4'b0101,
        OP_SBC = 4'b0110,
        OP_TST = 4'b1000,
        OP_CMP = 4'b1010,
        OP_ORR = 4'b1100,
        OP_MOV = 4'b1101,
        OP_MVN = 4'b1111
    } op_e;

    // ALU commands presented to EX
    typedef enum logic [EX_CMD_W-1:0] {
        EX_NOP = 4'b0000,
        EX_MOV = 4'b0001,
        EX_ADD = 4'b0010,
        EX_ADC = 4'b0011,
        EX_SUB = 4'b0100,
        EX_SBC = 4'b0101,
        EX_AND = 4'b0110,
        EX_ORR = 4'b0111,
        EX_EOR = 4'b1000,
        EX_MVN = 4'b1001
    } ex_cmd_e;

    // Commands that reuse another ALU operation
    localparam ex_cmd_e EX_CMP = EX_SUB;
    localparam ex_cmd_e EX_TST = EX_AND;
    localparam ex_cmd_e EX_LDR = EX_ADD;
    localparam ex_cmd_e EX_STR = EX_ADD;

    // Decoded control carried into EX
    typedef struct packed {
        logic                wb_en;
        logic                mem_r_en;
        logic                mem_w_en;
        logic                b;
        logic                s;
        logic [EX_CMD_W-1:0] exe_cmd;
    } id_ex_ctrl_t;

    // A bubble (valid=0) must never enable a side effect, and a simultaneous
    // load/store request is resolved in favour of the load.
    function automatic id_ex_ctrl_t sanitize_ctrl(input logic valid, input id_ex_ctrl_t c);
        id_ex_ctrl_t r;
        r          = c;
        r.wb_en    = valid & c.wb_en;
        r.mem_r_en = valid & c.mem_r_en;
        r.mem_w_en = valid & c.mem_w_en & ~c.mem_r_en;
        r.b        = valid & c.b;
        r.s        = valid & c.s;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_pipe_field.sv
// -----------------------------------------------------------------------------
// pipe_field
// W-bit pipeline register with synchronous reset, load enable and clear.
// Priority: rst > ~en (hold) > clr > load.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset (clears q)
//   en   in  1  update enable; 0 holds q (clr is ignored while holding)
//   clr  in  1  load zero instead of d
//   d    in  W  next value
//   q    out W  registered value
// -----------------------------------------------------------------------------
module pipe_field #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            if (clr) begin
                r_q <= '0;
            end else begin
                r_q <= d;
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register of the ARM-subset core. Captures decoded control,
// operands, immediates, destination and the NZCV snapshot; supports hold
// (freeze) and bubble insertion (flush). Priority: rst > freeze > flush > load.
// Optional feature macro: FORWARD_SRC_EN adds source-register fields for the
// EX forwarding unit.
// Ports (all *_out registered, latency 1):
//   clk, rst (sync, active high), freeze, flush
//   pc_in/out [WORD_W]        valid_in/out          wb_en_in/out
//   mem_r_en_in/out           mem_w_en_in/out       b_in/out, s_in/out
//   exe_cmd_in/out [CMD_W]    val_rn_in/out [WORD_W] val_rm_in/out [WORD_W]
//   imm_in/out                shift_op_in/out [12]  simm24_in/out [24]
//   dest_in/out [REG_ADDR_W]  sr_in/out [4]
//   FORWARD_SRC_EN only: src1_in/out, src2_in/out [REG_ADDR_W], two_src_in/out
// -----------------------------------------------------------------------------
module id_ex_stage_reg
    import core_pkg::*;
#(
    parameter int unsigned WORD_W     = CORE_WORD_W,
    parameter int unsigned CMD_W      = EX_CMD_W,
    parameter int unsigned REG_ADDR_W = CORE_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [WORD_W-1:0]     pc_in,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [CMD_W-1:0]      exe_cmd_in,
    input  logic [WORD_W-1:0]     val_rn_in,
    input  logic [WORD_W-1:0]     val_rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           shift_op_in,
    input  logic [23:0]           simm24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [3:0]            sr_in,
`ifdef FORWARD_SRC_EN
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic                  two_src_in,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic                  two_src_out,
`endif
    output logic [WORD_W-1:0]     pc_out,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [CMD_W-1:0]      exe_cmd_out,
    output logic [WORD_W-1:0]     val_rn_out,
    output logic [WORD_W-1:0]     val_rm_out,
    output logic                  imm_out,
    output logic [11:0]           shift_op_out,
    output logic [23:0]           simm24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [3:0]            sr_out
);

    localparam int unsigned CTRL_W = 1 + $bits(id_ex_ctrl_t);
    localparam int unsigned OPND_W = 3 * WORD_W;
    localparam int unsigned IMM_W  = 1 + 12 + 24;
    localparam int unsigned DSR_W  = REG_ADDR_W + 4;

    logic              w_en;
    id_ex_ctrl_t       w_ctrl_raw;
    id_ex_ctrl_t       w_ctrl_in;
    id_ex_ctrl_t       w_ctrl_q;
    logic [CTRL_W-1:0] w_ctrl_grp_q;
    logic [OPND_W-1:0] w_opnd_q;
    logic [IMM_W-1:0]  w_imm_q;
    logic [DSR_W-1:0]  w_dsr_q;

    assign w_en = ~freeze;

    always_comb begin
        w_ctrl_raw          = '0;
        w_ctrl_raw.wb_en    = wb_en_in;
        w_ctrl_raw.mem_r_en = mem_r_en_in;
        w_ctrl_raw.mem_w_en = mem_w_en_in;
        w_ctrl_raw.b        = b_in;
        w_ctrl_raw.s        = s_in;
        w_ctrl_raw.exe_cmd  = EX_CMD_W'(exe_cmd_in);
    end

    assign w_ctrl_in = sanitize_ctrl(valid_in, w_ctrl_raw);

    // Control group: valid bit plus sanitized control bundle
    pipe_field #(.W(CTRL_W)) u_ctrl (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   ({valid_in, w_ctrl_in}),
        .q   (w_ctrl_grp_q)
    );

    assign valid_out    = w_ctrl_grp_q[CTRL_W-1];
    assign w_ctrl_q     = w_ctrl_grp_q[CTRL_W-2:0];
    assign wb_en_out    = w_ctrl_q.wb_en;
    assign mem_r_en_out = w_ctrl_q.mem_r_en;
    assign mem_w_en_out = w_ctrl_q.mem_w_en;
    assign b_out        = w_ctrl_q.b;
    assign s_out        = w_ctrl_q.s;
    assign exe_cmd_out  = CMD_W'(w_ctrl_q.exe_cmd);

    // Operand group: PC+4, Rn, Rm
    pipe_field #(.W(OPND_W)) u_opnd (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   ({pc_in, val_rn_in, val_rm_in}),
        .q   (w_opnd_q)
    );

    assign {pc_out, val_rn_out, val_rm_out} = w_opnd_q;

    // Immediate group: I bit, shifter operand, branch offset
    pipe_field #(.W(IMM_W)) u_imm (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   ({imm_in, shift_op_in, simm24_in}),
        .q   (w_imm_q)
    );

    assign {imm_out, shift_op_out, simm24_out} = w_imm_q;

    // Destination register and status snapshot
    pipe_field #(.W(DSR_W)) u_dsr (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   ({dest_in, sr_in}),
        .q   (w_dsr_q)
    );

    assign {dest_out, sr_out} = w_dsr_q;

`ifdef FORWARD_SRC_EN
    localparam int unsigned SRC_W = 2 * REG_ADDR_W + 1;

    logic [SRC_W-1:0] w_src_q;

    // Source registers for the forwarding unit
    pipe_field #(.W(SRC_W)) u_src (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   ({src1_in, src2_in, two_src_in}),
        .q   (w_src_q)
    );

    assign {src1_out, src2_out, two_src_out} = w_src_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed stimulus for id_ex_stage_reg; expected outputs are queued per clock
// edge and checked by an independent monitor a few ns after each edge.
// Honours FORWARD_SRC_EN if defined.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in, dest_in, sr_in;
    logic [11:0] shift_op_in;
    logic [23:0] simm24_in;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [3:0]  exe_cmd_out, dest_out, sr_out;
    logic [11:0] shift_op_out;
    logic [23:0] simm24_out;
`ifdef FORWARD_SRC_EN
    logic [3:0]  src1_in, src2_in, src1_out, src2_out;
    logic        two_src_in, two_src_out;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic [31:0] rn, rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest, sr;
        logic [3:0]  src1, src2;
        logic        two;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.WORD_W(32), .CMD_W(4), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .valid_in(valid_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
        .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .imm_in(imm_in), .shift_op_in(shift_op_in), .simm24_in(simm24_in),
        .dest_in(dest_in), .sr_in(sr_in),
`ifdef FORWARD_SRC_EN
        .src1_in(src1_in), .src2_in(src2_in), .two_src_in(two_src_in),
        .src1_out(src1_out), .src2_out(src2_out), .two_src_out(two_src_out),
`endif
        .pc_out(pc_out), .valid_out(valid_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
        .exe_cmd_out(exe_cmd_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_op_out(shift_op_out), .simm24_out(simm24_out),
        .dest_out(dest_out), .sr_out(sr_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: every edge that has a queued expectation is checked 3 ns later
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid_out",    32'(valid_out),    32'(e.valid));
                chk("pc_out",       pc_out,            e.pc);
                chk("wb_en_out",    32'(wb_en_out),    32'(e.wb));
                chk("mem_r_en_out", 32'(mem_r_en_out), 32'(e.mr));
                chk("mem_w_en_out", 32'(mem_w_en_out), 32'(e.mw));
                chk("b_out",        32'(b_out),        32'(e.b));
                chk("s_out",        32'(s_out),        32'(e.s));
                chk("exe_cmd_out",  32'(exe_cmd_out),  32'(e.cmd));
                chk("val_rn_out",   val_rn_out,        e.rn);
                chk("val_rm_out",   val_rm_out,        e.rm);
                chk("imm_out",      32'(imm_out),      32'(e.imm));
                chk("shift_op_out", 32'(shift_op_out), 32'(e.shop));
                chk("simm24_out",   32'(simm24_out),   32'(e.simm));
                chk("dest_out",     32'(dest_out),     32'(e.dest));
                chk("sr_out",       32'(sr_out),       32'(e.sr));
`ifdef FORWARD_SRC_EN
                chk("src1_out",     32'(src1_out),     32'(e.src1));
                chk("src2_out",     32'(src2_out),     32'(e.src2));
                chk("two_src_out",  32'(two_src_out),  32'(e.two));
`endif
            end
        end
    end

    // Stimulus helpers: each drive_* applies one instruction; the matching
    // e_* is the hand-written expected output once it is loaded.
    task automatic drive_ones();
        {pc_in, val_rn_in, val_rm_in} = '1;
        {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = '1;
        {exe_cmd_in, dest_in, sr_in, shift_op_in, simm24_in} = '1;
`ifdef FORWARD_SRC_EN
        {src1_in, src2_in, two_src_in} = '1;
`endif
    endtask

    task automatic drive_zero();
        {pc_in, val_rn_in, val_rm_in} = '0;
        {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = '0;
        {exe_cmd_in, dest_in, sr_in, shift_op_in, simm24_in} = '0;
`ifdef FORWARD_SRC_EN
        {src1_in, src2_in, two_src_in} = '0;
`endif
    endtask

    task automatic drive_add();
        drive_zero();
        valid_in = 1'b1; pc_in = 32'h104; wb_en_in = 1'b1; exe_cmd_in = 4'b0010;
        val_rn_in = 32'd5; val_rm_in = 32'd7; dest_in = 4'd3; sr_in = 4'b0010;
`ifdef FORWARD_SRC_EN
        src1_in = 4'd1; src2_in = 4'd2; two_src_in = 1'b1;
`endif
    endtask

    function automatic out_t e_add();
        out_t e = '0;
        e.valid = 1'b1; e.pc = 32'h104; e.wb = 1'b1; e.cmd = 4'b0010;
        e.rn = 32'd5; e.rm = 32'd7; e.dest = 4'd3; e.sr = 4'b0010;
`ifdef FORWARD_SRC_EN
        e.src1 = 4'd1; e.src2 = 4'd2; e.two = 1'b1;
`endif
        return e;
    endfunction

    task automatic drive_sub();
        drive_zero();
        valid_in = 1'b1; pc_in = 32'h108; wb_en_in = 1'b1; s_in = 1'b1; exe_cmd_in = 4'b0100;
        val_rn_in = 32'd9; val_rm_in = 32'd2; dest_in = 4'd4; imm_in = 1'b1;
        shift_op_in = 12'h00A; sr_in = 4'b1000;
    endtask

    function automatic out_t e_sub();
        out_t e = '0;
        e.valid = 1'b1; e.pc = 32'h108; e.wb = 1'b1; e.s = 1'b1; e.cmd = 4'b0100;
        e.rn = 32'd9; e.rm = 32'd2; e.dest = 4'd4; e.imm = 1'b1;
        e.shop = 12'h00A; e.sr = 4'b1000;
        return e;
    endfunction

    task automatic drive_str();
        drive_zero();
        valid_in = 1'b1; pc_in = 32'h10C; mem_w_en_in = 1'b1; exe_cmd_in = 4'b0010;
        val_rn_in = 32'h100; val_rm_in = 32'hDEADBEEF; imm_in = 1'b1; shift_op_in = 12'h004;
    endtask

    function automatic out_t e_str();
        out_t e = '0;
        e.valid = 1'b1; e.pc = 32'h10C; e.mw = 1'b1; e.cmd = 4'b0010;
        e.rn = 32'h100; e.rm = 32'hDEADBEEF; e.imm = 1'b1; e.shop = 12'h004;
        return e;
    endfunction

    // All ones with valid=1: both memory enables requested, store must drop
    function automatic out_t e_ones();
        out_t e = '1;
        e.mw = 1'b0;
`ifndef FORWARD_SRC_EN
        e.src1 = '0; e.src2 = '0; e.two = 1'b0;
`endif
        return e;
    endfunction

    // valid_in=0 with enables requested: enables cleared, data still loads
    task automatic drive_bub();
        drive_zero();
        valid_in = 1'b0; pc_in = 32'h110; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
        b_in = 1'b1; s_in = 1'b1; exe_cmd_in = 4'b0100;
        val_rn_in = 32'h55; val_rm_in = 32'h66; dest_in = 4'd7;
    endtask

    function automatic out_t e_bub();
        out_t e = '0;
        e.pc = 32'h110; e.cmd = 4'b0100; e.rn = 32'h55; e.rm = 32'h66; e.dest = 4'd7;
        return e;
    endfunction

    // Queue the expectation for the coming edge, then release inputs 1 ns later
    task automatic step(input out_t e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; freeze = 1'b1; flush = 1'b1;
        drive_ones();
        // reset with every input high
        step('0);
        step('0);
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        // plain load
        drive_add();
        step(e_add());
        drive_str();
        step(e_str());
        drive_add();
        step(e_add());
        // freeze holds ADD while SUB waits on the inputs
        drive_sub();
        freeze = 1'b1;
        step(e_add());
        step(e_add());
        step(e_add());
        freeze = 1'b0;
        step(e_sub());
        // flush turns a store into a bubble
        drive_str();
        flush = 1'b1;
        step('0);
        flush = 1'b0;
        // flush during freeze is ignored, then flush alone bubbles
        drive_sub();
        step(e_sub());
        drive_str();
        flush = 1'b1; freeze = 1'b1;
        step(e_sub());
        freeze = 1'b0;
        step('0);
        flush = 1'b0;
        // illegal load+store and all-ones boundary
        drive_ones();
        step(e_ones());
        // invalid instruction with enables requested
        drive_bub();
        step(e_bub());
        // reset in the middle of a stall, then normal load
        drive_add();
        freeze = 1'b1;
        step(e_bub());
        rst = 1'b1;
        step('0);
        rst = 1'b0; freeze = 1'b0;
        step(e_add());
        repeat (2) @(posedge clk);
        #5;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
